// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x oversampling UART receiver with a configurable frame
// format, sticky error flags and a first-word-fall-through receive FIFO.
module uart_rx_fifo #(
   parameter int CLK_HZ     = 50_000_000,
   parameter int BAUD       = 115_200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             uart_rx,
   input  logic                             rd_en,
   input  logic                             clr_err,
   output logic [7:0]                       rd_data,
   output logic                             empty,
   output logic                             full,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  count,
   output logic                             frame_err,
   output logic                             parity_err,
   output logic                             overrun,
   output logic [2:0]                       rx_state
);

   localparam int DIV_R = (CLK_HZ + BAUD * 8) / (BAUD * 16);
   localparam int DIV   = (DIV_R < 1) ? 1 : DIV_R;
   localparam int DW    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CW    = $clog2(FIFO_DEPTH + 1);
   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      PAR   = 3'd3,
      STOP  = 3'd4,
      BRK   = 3'd5
   } state_t;

   logic                 sync1_q, sync2_q, rx_s;
   logic [DW-1:0]        div_q, div_d;
   logic                 tick;
   state_t               state_q, state_d;
   logic [3:0]           tcnt_q, tcnt_d;
   logic [2:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 par_q, par_d, par_ok;
   logic                 push_q, push_d;
   logic                 set_fe, set_pe, set_ov;
   logic                 fe_q, fe_d, pe_q, pe_d, ov_q, ov_d;
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 pop, wr;
   logic [7:0]           mem_q [FIFO_DEPTH];

   assign rx_s  = sync2_q;
   assign tick  = (div_q == DW'(DIV - 1));
   assign div_d = tick ? '0 : div_q + DW'(1);

   always_comb begin
      par_ok = 1'b1;
      if (PARITY == 1) par_ok = ^{shreg_q, par_q};
      else if (PARITY == 2) par_ok = ~^{shreg_q, par_q};
   end

   always_comb begin
      state_d = state_q;
      tcnt_d  = tcnt_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      par_d   = par_q;
      push_d  = 1'b0;
      set_fe  = 1'b0;
      set_pe  = 1'b0;
      if (tick) tcnt_d = tcnt_q + 4'd1;
      unique case (state_q)
         IDLE: begin
            if (!rx_s) begin
               tcnt_d  = '0;
               state_d = START;
            end
         end
         START: begin
            // Realign the tick phase to mid-start so later samples land mid-bit
            if (tick && tcnt_q == 4'd7) begin
               tcnt_d  = '0;
               bit_d   = '0;
               state_d = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (tick && tcnt_q == 4'd15) begin
               shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == LAST_BIT) state_d = (PARITY != 0) ? PAR : STOP;
            end
         end
         PAR: begin
            if (tick && tcnt_q == 4'd15) begin
               par_d   = rx_s;
               state_d = STOP;
            end
         end
         STOP: begin
            if (tick && tcnt_q == 4'd15) begin
               if (!rx_s) begin
                  set_fe  = 1'b1;
                  state_d = BRK;
               end else if (!par_ok) begin
                  set_pe  = 1'b1;
                  state_d = IDLE;
               end else begin
                  push_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         BRK: begin
            if (rx_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pop      = rd_en && (cnt_q != '0);
      // A pop in the same cycle frees the slot a full FIFO needs
      wr       = push_q && ((cnt_q != CW'(FIFO_DEPTH)) || pop);
      set_ov   = push_q && !wr;
      wr_ptr_d = wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      cnt_d    = cnt_q;
      if (wr && !pop) cnt_d = cnt_q + CW'(1);
      else if (pop && !wr) cnt_d = cnt_q - CW'(1);
      fe_d = set_fe | (fe_q & ~clr_err);
      pe_d = set_pe | (pe_q & ~clr_err);
      ov_d = set_ov | (ov_q & ~clr_err);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         div_q    <= '0;
         state_q  <= IDLE;
         tcnt_q   <= '0;
         bit_q    <= '0;
         shreg_q  <= '0;
         par_q    <= 1'b0;
         push_q   <= 1'b0;
         fe_q     <= 1'b0;
         pe_q     <= 1'b0;
         ov_q     <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= uart_rx;
         sync2_q  <= sync1_q;
         div_q    <= div_d;
         state_q  <= state_d;
         tcnt_q   <= tcnt_d;
         bit_q    <= bit_d;
         shreg_q  <= shreg_d;
         par_q    <= par_d;
         push_q   <= push_d;
         fe_q     <= fe_d;
         pe_q     <= pe_d;
         ov_q     <= ov_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr) mem_q[wr_ptr_q] <= 8'(shreg_q);
   end

   assign rd_data    = (cnt_q == '0) ? 8'd0 : mem_q[rd_ptr_q];
   assign empty      = (cnt_q == '0);
   assign full       = (cnt_q == CW'(FIFO_DEPTH));
   assign count      = cnt_q;
   assign frame_err  = fe_q;
   assign parity_err = pe_q;
   assign overrun    = ov_q;
   assign rx_state   = state_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: three receiver configurations (8N1/4, 7E1/16, 5O1/2)
// driven with serial frames and compared against a queue-based model.
module tb_uart_rx_fifo;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       rx  [3];
   logic       rd  [3];
   logic       clr [3];
   logic [7:0] rdd [3];
   logic       emp [3];
   logic       ful [3];
   logic       fe  [3];
   logic       pe  [3];
   logic       ov  [3];
   logic [2:0] st  [3];
   logic [2:0] c0;
   logic [4:0] c1;
   logic [1:0] c2;
   integer     cnt [3];

   assign cnt[0] = 32'(c0);
   assign cnt[1] = 32'(c1);
   assign cnt[2] = 32'(c2);

   int NB [3] = '{8, 7, 5};
   int PR [3] = '{0, 2, 1};
   int DP [3] = '{4, 16, 2};

   logic [7:0] q [3][$];
   bit mfe [3];
   bit mpe [3];
   bit mov [3];
   int checks = 0;
   int errors = 0;

   uart_rx_fifo #(.CLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(8),
      .PARITY(0), .FIFO_DEPTH(4)) u0 (
      .clk(clk), .rst(rst), .uart_rx(rx[0]), .rd_en(rd[0]),
      .clr_err(clr[0]), .rd_data(rdd[0]), .empty(emp[0]), .full(ful[0]),
      .count(c0), .frame_err(fe[0]), .parity_err(pe[0]),
      .overrun(ov[0]), .rx_state(st[0]));

   uart_rx_fifo #(.CLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(7),
      .PARITY(2), .FIFO_DEPTH(16)) u1 (
      .clk(clk), .rst(rst), .uart_rx(rx[1]), .rd_en(rd[1]),
      .clr_err(clr[1]), .rd_data(rdd[1]), .empty(emp[1]), .full(ful[1]),
      .count(c1), .frame_err(fe[1]), .parity_err(pe[1]),
      .overrun(ov[1]), .rx_state(st[1]));

   uart_rx_fifo #(.CLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(5),
      .PARITY(1), .FIFO_DEPTH(2)) u2 (
      .clk(clk), .rst(rst), .uart_rx(rx[2]), .rd_en(rd[2]),
      .clr_err(clr[2]), .rd_data(rdd[2]), .empty(emp[2]), .full(ful[2]),
      .count(c2), .frame_err(fe[2]), .parity_err(pe[2]),
      .overrun(ov[2]), .rx_state(st[2]));

   // Drives one frame and applies the frame rules to the model.
   task automatic send_frame(input int u, input logic [7:0] d,
                             input bit flip, input bit stop_lvl,
                             input bit pulse_rd);
      logic [7:0] m;
      int ones;
      bit pb;
      bit got;
      m    = d & 8'((1 << NB[u]) - 1);
      ones = $countones(m);
      pb   = (PR[u] == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
      if (flip) pb = !pb;
      got = 0;
      @(negedge clk);
      rx[u] = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < NB[u]; i++) begin
         rx[u] = m[i];
         repeat (16) @(negedge clk);
      end
      if (PR[u] != 0) begin
         rx[u] = pb;
         repeat (16) @(negedge clk);
      end
      rx[u] = stop_lvl;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (rd[u]) rd[u] = 1'b0;
         else if (pulse_rd && !got && st[u] == 3'd0) begin
            rd[u] = 1'b1;
            got = 1;
         end
      end
      rx[u] = 1'b1;
      repeat (6) @(negedge clk);
      if (pulse_rd) begin
         checks++;
         if (!got) begin
            errors++;
            $display("FAIL push_window u%0d got none exp state 0 in stop bit", u);
         end
      end
      if (!stop_lvl) mfe[u] = 1;
      else if (PR[u] != 0 && flip) mpe[u] = 1;
      else begin
         if (got && q[u].size() > 0) void'(q[u].pop_front());
         if (q[u].size() < DP[u]) q[u].push_back(m);
         else mov[u] = 1;
      end
   endtask

   task automatic do_pop(input int u);
      @(negedge clk);
      rd[u] = 1'b1;
      @(negedge clk);
      rd[u] = 1'b0;
      if (q[u].size() > 0) void'(q[u].pop_front());
   endtask

   task automatic do_clr(input int u);
      @(negedge clk);
      clr[u] = 1'b1;
      @(negedge clk);
      clr[u] = 1'b0;
      mfe[u] = 0;
      mpe[u] = 0;
      mov[u] = 0;
   endtask

   task automatic test_reset;
      for (int u = 0; u < 3; u++) begin
         rx[u] = 1'b1; rd[u] = 1'b0; clr[u] = 1'b0;
      end
      rst = 1'b1;
      repeat (4) @(negedge clk);
      for (int u = 0; u < 3; u++) begin
         checks++;
         if (st[u] !== 3'd0 || emp[u] !== 1'b1 || ful[u] !== 1'b0) begin
            errors++;
            $display("FAIL rst_state u%0d got st=%0d e=%b f=%b exp 0/1/0",
                     u, st[u], emp[u], ful[u]);
         end
         checks++;
         if (cnt[u] !== 0 || rdd[u] !== 8'd0) begin
            errors++;
            $display("FAIL rst_fifo u%0d got cnt=%0d data=%h exp 0/00",
                     u, cnt[u], rdd[u]);
         end
         checks++;
         if ({fe[u], pe[u], ov[u]} !== 3'b000) begin
            errors++;
            $display("FAIL rst_flags u%0d got %b exp 000", u,
                     {fe[u], pe[u], ov[u]});
         end
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_8n1;
      logic [7:0] b;
      send_frame(0, 8'hA5, 0, 1, 0);
      checks++;
      if (emp[0] !== 1'b0 || cnt[0] !== 1 || rdd[0] !== 8'hA5) begin
         errors++;
         $display("FAIL a5 got e=%b cnt=%0d data=%h exp 0/1/a5",
                  emp[0], cnt[0], rdd[0]);
      end
      do_pop(0);
      checks++;
      if (emp[0] !== 1'b1) begin
         errors++;
         $display("FAIL a5_pop got empty=%b exp 1", emp[0]);
      end
      for (int i = 0; i < 8; i++) begin
         b = 8'($urandom);
         send_frame(0, b, 0, 1, 0);
         checks++;
         if (cnt[0] !== q[0].size() || rdd[0] !== q[0][0]) begin
            errors++;
            $display("FAIL 8n1_rand got cnt=%0d data=%h exp %0d/%h",
                     cnt[0], rdd[0], q[0].size(), q[0][0]);
         end
         checks++;
         if (ov[0] !== mov[0]) begin
            errors++;
            $display("FAIL 8n1_ovr got %b exp %b", ov[0], mov[0]);
         end
         if ($urandom_range(0, 1) == 1) do_pop(0);
      end
      while (q[0].size() > 0) begin
         checks++;
         if (rdd[0] !== q[0][0]) begin
            errors++;
            $display("FAIL 8n1_drain got %h exp %h", rdd[0], q[0][0]);
         end
         do_pop(0);
      end
      do_clr(0);
   endtask

   task automatic test_7e1;
      logic [7:0] b;
      bit fl;
      send_frame(1, 8'h55, 0, 1, 0);
      checks++;
      if (rdd[1] !== 8'h55 || cnt[1] !== 1) begin
         errors++;
         $display("FAIL 7e1_good got data=%h cnt=%0d exp 55/1", rdd[1], cnt[1]);
      end
      send_frame(1, 8'h55, 1, 1, 0);
      checks++;
      if (pe[1] !== 1'b1 || cnt[1] !== 1) begin
         errors++;
         $display("FAIL 7e1_bad got pe=%b cnt=%0d exp 1/1", pe[1], cnt[1]);
      end
      do_clr(1);
      checks++;
      if (pe[1] !== 1'b0) begin
         errors++;
         $display("FAIL 7e1_clr got %b exp 0", pe[1]);
      end
      for (int i = 0; i < 8; i++) begin
         b  = 8'($urandom);
         fl = ($urandom_range(0, 3) == 0);
         send_frame(1, b, fl, 1, 0);
         checks++;
         if (cnt[1] !== q[1].size() || rdd[1] !== q[1][0]) begin
            errors++;
            $display("FAIL 7e1_rand got cnt=%0d data=%h exp %0d/%h",
                     cnt[1], rdd[1], q[1].size(), q[1][0]);
         end
         checks++;
         if (pe[1] !== mpe[1]) begin
            errors++;
            $display("FAIL 7e1_pe got %b exp %b", pe[1], mpe[1]);
         end
      end
      while (q[1].size() > 0) do_pop(1);
      do_clr(1);
   endtask

   task automatic test_5o1;
      logic [7:0] b;
      bit fl;
      for (int i = 0; i < 10; i++) begin
         b  = 8'($urandom);
         fl = ($urandom_range(0, 3) == 0);
         send_frame(2, b, fl, 1, 0);
         checks++;
         if (cnt[2] !== q[2].size() || ful[2] !== (q[2].size() == 2)) begin
            errors++;
            $display("FAIL 5o1_cnt got cnt=%0d full=%b exp %0d",
                     cnt[2], ful[2], q[2].size());
         end
         if (q[2].size() > 0) begin
            checks++;
            if (rdd[2] !== q[2][0]) begin
               errors++;
               $display("FAIL 5o1_data got %h exp %h", rdd[2], q[2][0]);
            end
         end
         checks++;
         if ({pe[2], ov[2]} !== {mpe[2], mov[2]}) begin
            errors++;
            $display("FAIL 5o1_flags got %b%b exp %b%b",
                     pe[2], ov[2], mpe[2], mov[2]);
         end
         if ($urandom_range(0, 2) == 0) do_pop(2);
      end
      while (q[2].size() > 0) do_pop(2);
      do_clr(2);
   endtask

   task automatic test_break;
      @(negedge clk);
      rx[0] = 1'b0;
      repeat (480) @(negedge clk);
      mfe[0] = 1;
      checks++;
      if (fe[0] !== 1'b1 || st[0] !== 3'd5 || cnt[0] !== 0) begin
         errors++;
         $display("FAIL break got fe=%b st=%0d cnt=%0d exp 1/5/0",
                  fe[0], st[0], cnt[0]);
      end
      rx[0] = 1'b1;
      repeat (6) @(negedge clk);
      checks++;
      if (st[0] !== 3'd0 || fe[0] !== 1'b1) begin
         errors++;
         $display("FAIL break_end got st=%0d fe=%b exp 0/1", st[0], fe[0]);
      end
      do_clr(0);
      send_frame(0, 8'h3C, 0, 1, 0);
      checks++;
      if (rdd[0] !== 8'h3C || cnt[0] !== 1 || fe[0] !== 1'b0) begin
         errors++;
         $display("FAIL after_break got data=%h cnt=%0d fe=%b exp 3c/1/0",
                  rdd[0], cnt[0], fe[0]);
      end
      do_pop(0);
   endtask

   task automatic test_false_start;
      @(negedge clk);
      rx[0] = 1'b0;
      repeat (4) @(negedge clk);
      rx[0] = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if (st[0] !== 3'd0 || cnt[0] !== 0 || fe[0] !== 1'b0) begin
         errors++;
         $display("FAIL false_start got st=%0d cnt=%0d fe=%b exp 0/0/0",
                  st[0], cnt[0], fe[0]);
      end
   endtask

   task automatic test_fifo;
      logic [7:0] b;
      do_pop(0);
      checks++;
      if (cnt[0] !== 0 || emp[0] !== 1'b1) begin
         errors++;
         $display("FAIL pop_empty got cnt=%0d e=%b exp 0/1", cnt[0], emp[0]);
      end
      for (int i = 1; i <= 5; i++) send_frame(0, 8'(i), 0, 1, 0);
      checks++;
      if (ful[0] !== 1'b1 || cnt[0] !== 4 || ov[0] !== 1'b1) begin
         errors++;
         $display("FAIL overrun got full=%b cnt=%0d ov=%b exp 1/4/1",
                  ful[0], cnt[0], ov[0]);
      end
      for (int i = 1; i <= 4; i++) begin
         checks++;
         if (rdd[0] !== 8'(i)) begin
            errors++;
            $display("FAIL ovr_read got %h exp %h", rdd[0], 8'(i));
         end
         do_pop(0);
      end
      do_clr(0);
      for (int i = 0; i < 4; i++) send_frame(0, 8'($urandom), 0, 1, 0);
      send_frame(0, 8'hC3, 0, 1, 1);
      checks++;
      if (ov[0] !== 1'b0 || cnt[0] !== 4 || ful[0] !== 1'b1) begin
         errors++;
         $display("FAIL pop_push_full got ov=%b cnt=%0d full=%b exp 0/4/1",
                  ov[0], cnt[0], ful[0]);
      end
      while (q[0].size() > 0) begin
         checks++;
         if (rdd[0] !== q[0][0]) begin
            errors++;
            $display("FAIL full_drain got %h exp %h", rdd[0], q[0][0]);
         end
         do_pop(0);
      end
      for (int i = 0; i < 10; i++) begin
         b = 8'($urandom);
         send_frame(0, b, 0, 1, 0);
         checks++;
         if (rdd[0] !== b || cnt[0] !== 1) begin
            errors++;
            $display("FAIL wrap got data=%h cnt=%0d exp %h/1", rdd[0], cnt[0], b);
         end
         do_pop(0);
      end
      checks++;
      if (emp[0] !== 1'b1 || ov[0] !== 1'b0) begin
         errors++;
         $display("FAIL wrap_end got e=%b ov=%b exp 1/0", emp[0], ov[0]);
      end
   endtask

   task automatic test_reset_midframe;
      send_frame(0, 8'h77, 0, 1, 0);
      @(negedge clk);
      rx[0] = 1'b0;
      repeat (40) @(negedge clk);
      checks++;
      if (st[0] !== 3'd2 || cnt[0] !== 1) begin
         errors++;
         $display("FAIL midframe got st=%0d cnt=%0d exp 2/1", st[0], cnt[0]);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (st[0] !== 3'd0 || cnt[0] !== 0 || emp[0] !== 1'b1 || rdd[0] !== 8'd0) begin
         errors++;
         $display("FAIL async_rst got st=%0d cnt=%0d e=%b data=%h exp 0/0/1/00",
                  st[0], cnt[0], emp[0], rdd[0]);
      end
      rx[0] = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int u = 0; u < 3; u++) begin
         q[u].delete();
         mfe[u] = 0; mpe[u] = 0; mov[u] = 0;
      end
      send_frame(0, 8'h81, 0, 1, 0);
      checks++;
      if (rdd[0] !== 8'h81 || cnt[0] !== 1) begin
         errors++;
         $display("FAIL post_rst got data=%h cnt=%0d exp 81/1", rdd[0], cnt[0]);
      end
   endtask

   initial begin
      test_reset;
      test_8n1;
      test_7e1;
      test_5o1;
      test_break;
      test_false_start;
      test_fifo;
      test_reset_midframe;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with a configurable frame format, 16x oversampling and a receive FIFO. It is the next-generation replacement for the fixed 8N1 receiver behind the RV32I `UART_rx` pin. Received bytes are buffered so the core can poll or drain them through its memory-mapped peripheral bus. Framing, parity and overrun errors are reported as sticky flags.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency in Hz
- `BAUD`, 115_200, line rate in bit/s
- `DATA_BITS`, 8, data bits per frame, legal 5..8
- `PARITY`, 0, 0 = none, 1 = odd, 2 = even
- `FIFO_DEPTH`, 16, receive FIFO entries, power of two, ≥ 2

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `uart_rx`  in  1  serial line, asynchronous to `clk`, idles high
- `rd_en`  in  1  pop the FIFO head
- `clr_err`  in  1  clear all sticky error flags
- `rd_data`  out  8  FIFO head, zero-extended above `DATA_BITS`
- `empty`  out  1  FIFO holds no entries
- `full`  out  1  FIFO holds `FIFO_DEPTH` entries
- `count`  out  $clog2(FIFO_DEPTH+1)  number of entries
- `frame_err`  out  1  sticky flag: stop bit sampled low
- `parity_err`  out  1  sticky flag: parity mismatch
- `overrun`  out  1  sticky flag: byte dropped because the FIFO was full
- `rx_state`  out  3  current FSM state, for debug

## Operation
- `uart_rx` passes through a 2-FF synchroniser. The synchroniser resets to 1.
- Tick generator: `DIV = max(1, round(CLK_HZ/(BAUD*16)))`. It produces a 1-cycle `tick` every `DIV` clocks and free-runs from reset.
- FSM states, with encodings:
  - IDLE 0: wait for the synchronised line to go low, then clear the tick counter and go to START.
  - START 1: after 8 ticks, re-sample. Low → DATA. High → IDLE (false start, nothing pushed).
  - DATA 2: sample every 16 ticks, LSB first, `DATA_BITS` samples. Then go to PARITY if `PARITY != 0`, else STOP.
  - PARITY 3: sample after 16 ticks and compare. Odd parity requires an odd count of ones over data+parity; even parity requires an even count. Go to STOP.
  - STOP 4: sample after 16 ticks.
    - High, parity OK → push the byte, go to IDLE.
    - High, parity bad → set `parity_err`, do not push, go to IDLE.
    - Low → set `frame_err`, do not push, go to BREAK.
  - BREAK 5: wait for the line to go high, then go to IDLE. This stops a held-low line from generating repeated frames.
- Push when the FIFO is full and `rd_en` is low: the byte is dropped and `overrun` is set.
- Push when the FIFO is full and `rd_en` is high in the same cycle: the pop happens first and the push succeeds. No overrun.
- The FIFO is first-word-fall-through: `rd_data` is valid whenever `empty` is 0.
- `rd_en` while empty is ignored; pointers and `count` do not change.
- Simultaneous push and pop on a non-empty FIFO: `count` is unchanged.
- Pointers are `$clog2(FIFO_DEPTH)` bits and wrap modulo `FIFO_DEPTH`. `full`/`empty` are derived from `count`.
- Sticky flags stay set until `clr_err`. If `clr_err` coincides with a new error event, the flag ends up set (set wins).

## Timing
- Reset values:
  - `rx_state` = IDLE
  - `empty` = 1, `full` = 0, `count` = 0
  - `rd_data` = 0
  - all error flags 0
  - tick counter 0, FIFO pointers 0
- Line-to-FSM latency: 2 clocks (synchroniser). The start edge is detected on the next clock.
- Sample points fall at the mid-bit of each bit, 16 ticks apart, ±1 tick of synchroniser and detection jitter.
- Push occurs on the clock after the STOP mid-bit sample. `empty` falls and `count` increments on that same edge.
- Pop: `count`/pointers update on the `rd_en` edge. The new head appears on `rd_data` on that edge.
- Reset asserted mid-frame aborts the frame immediately. All state returns to reset values and FIFO contents are discarded.

## Test plan
- Reset/idle: with `CLK_HZ`=1_600_000, `BAUD`=100_000 (DIV=1, 16 clk/bit), hold `rst` for 4 clocks with the line high → all outputs at reset values, `rx_state`=0.
- 8N1 byte: send 0xA5 → after ~160 clocks, `empty`=0, `count`=1, `rd_data`=0xA5. After one `rd_en`, `empty`=1.
- 7E1 and parity error: with `DATA_BITS`=7, `PARITY`=2, send 0x55 with correct parity → `rd_data`=0x55. Then send it with the parity bit flipped → `parity_err`=1, `count` unchanged. `clr_err` → 0.
- Frame error / break: drive the line low for 30 bit times → `frame_err`=1, `rx_state`=5 until the line goes high, no push. Then send 0x3C → received correctly.
- False start: a 4-clock low glitch → `rx_state` returns to 0, `count`=0.
- FIFO full/overrun/wrap, `FIFO_DEPTH`=4:
  - send 0x01..0x05 without reading → `full`=1, `count`=4, `overrun`=1, and reads return 0x01..0x04.
  - send a 6th byte while pulsing `rd_en` on its push cycle → no overrun.
  - run 10 more bytes with read-as-received → data in order across pointer wrap.
